// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution result serializer.
// CONV_SER_CHECKSUM_EN selects the LAST_CSUM index in the serializer.
package conv_pkg;

    localparam int DATA_W   = 8;
    localparam int NUM_ELEM = 9;
    localparam int WORD_W   = DATA_W * NUM_ELEM;

    typedef logic [DATA_W-1:0] elem_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    localparam logic [3:0] LAST_PLAIN = 4'd8;
    localparam logic [3:0] LAST_CSUM  = 4'd9;

    function automatic elem_t get_elem(input word_t w, input logic [3:0] i);
        elem_t e;
        e = '0;
        for (int k = 0; k < NUM_ELEM; k++) begin
            if (i == 4'(k)) e = w[k*DATA_W +: DATA_W];
        end
        return e;
    endfunction

    function automatic elem_t xor_elems(input word_t w);
        elem_t e;
        e = '0;
        for (int k = 0; k < NUM_ELEM; k++) begin
            e = e ^ w[k*DATA_W +: DATA_W];
        end
        return e;
    endfunction

endpackage

// File: rtl/conv_word_store.sv
// Two-entry ping-pong word store with write/read pointers and occupancy.
// Capture and free in one cycle move both pointers and keep occupancy.
module conv_word_store
    import conv_pkg::*;
#(
    parameter int W = WORD_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_free,
    output logic [W-1:0] rd_data,
    output logic [1:0]   cnt
);

    logic [W-1:0] mem0;
    logic [W-1:0] mem1;
    logic         wp;
    logic         rp;
    occ_t         occ;
    occ_t         occ_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem0 <= '0;
            mem1 <= '0;
            wp   <= 1'b0;
            rp   <= 1'b0;
            occ  <= EMPTY;
        end else begin
            if (wr_en) begin
                if (wp) mem1 <= wr_data;
                else    mem0 <= wr_data;
                wp <= ~wp;
            end
            if (rd_free) rp <= ~rp;
            occ <= occ_nxt;
        end
    end

    always_comb begin
        occ_nxt = occ;
        case (occ)
            EMPTY: if (wr_en) occ_nxt = ONE;
            ONE: begin
                if (wr_en && !rd_free)      occ_nxt = FULL;
                else if (!wr_en && rd_free) occ_nxt = EMPTY;
            end
            FULL: if (rd_free && !wr_en) occ_nxt = ONE;
            default: occ_nxt = EMPTY;
        endcase
    end

    assign rd_data = rp ? mem1 : mem0;
    assign cnt     = occ;

endmodule

// File: rtl/conv_result_serializer.sv
// Serializes 72-bit convolution results to a byte stream with drop counting.
// Define CONV_SER_CHECKSUM_EN to append an XOR checksum byte per word.
module conv_result_serializer
    import conv_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATA_W*NUM_ELEM-1:0] in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [3:0]                 out_index,
    output logic                       out_last,
    output logic [7:0]                 drop_cnt
);

`ifdef CONV_SER_CHECKSUM_EN
    localparam int         SW   = WORD_W + DATA_W;
    localparam logic [3:0] LAST = LAST_CSUM;
`else
    localparam int         SW   = WORD_W;
    localparam logic [3:0] LAST = LAST_PLAIN;
`endif

    logic [SW-1:0] wr_word;
    logic [SW-1:0] rd_word;
    logic [1:0]    cnt;
    logic [3:0]    idx;
    logic [7:0]    drops;
    logic          capture;
    logic          drop;
    logic          xfer;
    logic          free;

    // Room is judged on registered occupancy; a same-cycle free does not help.
    assign capture = in_valid && (cnt != FULL);
    assign drop    = in_valid && (cnt == FULL);
    assign xfer    = out_valid && out_ready;
    assign free    = xfer && (idx == LAST);

`ifdef CONV_SER_CHECKSUM_EN
    assign wr_word = {xor_elems(in_data), in_data};
`else
    assign wr_word = in_data;
`endif

    conv_word_store #(.W(SW)) u_store (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (capture),
        .wr_data (wr_word),
        .rd_free (free),
        .rd_data (rd_word),
        .cnt     (cnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx   <= '0;
            drops <= '0;
        end else begin
            if (xfer) idx <= (idx == LAST) ? 4'd0 : idx + 4'd1;
            if (drop && drops != 8'hFF) drops <= drops + 8'd1;
        end
    end

    always_comb begin
        out_data = get_elem(rd_word[WORD_W-1:0], idx);
`ifdef CONV_SER_CHECKSUM_EN
        if (idx == LAST_CSUM) out_data = rd_word[SW-1 -: DATA_W];
`endif
    end

    assign in_ready  = (cnt != FULL);
    assign out_valid = (cnt != EMPTY);
    assign out_index = idx;
    assign out_last  = (idx == LAST);
    assign drop_cnt  = drops;

endmodule

// File: tb/tb_conv_result_serializer.sv
// Directed self-checking bench for conv_result_serializer.
// Honors CONV_SER_CHECKSUM_EN for the expected byte count and checksum.
module tb_conv_result_serializer;

`ifdef CONV_SER_CHECKSUM_EN
    localparam int LAST = 9;
`else
    localparam int LAST = 8;
`endif

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [71:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [3:0]  out_index;
    logic        out_last;
    logic [7:0]  drop_cnt;

    int tests;
    int fails;

    localparam logic [71:0] W1 = 72'h090807060504030201;
    localparam logic [71:0] W2 = 72'hA8A7A6A5A4A3A2A1A0;
    localparam logic [71:0] W3 = 72'h5F4E3D2C1B0A39281F;
    localparam logic [71:0] W4 = 72'hEEEEEEEEEEEEEEEEEE;
    localparam logic [71:0] W5 = 72'h998877665544332211;

    conv_result_serializer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got,
                         input logic [71:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_byte(input logic [71:0] w,
                                            input int k);
        logic [7:0] x;
        if (k < 9) return w[k*8 +: 8];
        x = '0;
        for (int j = 0; j < 9; j++) x = x ^ w[j*8 +: 8];
        return x;
    endfunction

    task automatic check_byte(input string tag, input logic [71:0] w,
                              input int k);
        check({tag, " valid"}, 72'(out_valid), 72'd1);
        check({tag, " data"}, 72'(out_data), 72'(exp_byte(w, k)));
        check({tag, " index"}, 72'(out_index), 72'(k));
        check({tag, " last"}, 72'(out_last), 72'(k == LAST));
    endtask

    task automatic send(input logic [71:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int k;
        tests     = 0;
        fails     = 0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        reset     = 1'b1;
        tick();
        check("rst out_valid", 72'(out_valid), 72'd0);
        check("rst out_data", 72'(out_data), 72'd0);
        check("rst out_index", 72'(out_index), 72'd0);
        check("rst out_last", 72'(out_last), 72'd0);
        check("rst in_ready", 72'(in_ready), 72'd1);
        check("rst drop_cnt", 72'(drop_cnt), 72'd0);
        tick();
        reset = 1'b0;

        // single word, one-cycle latency, one byte per cycle
        send(W1);
        for (int i = 0; i <= LAST; i++) begin
            check_byte("w1", W1, i);
            tick();
        end
        check("w1 idle", 72'(out_valid), 72'd0);

        // back-to-back words stream without a bubble
        in_valid = 1'b1;
        in_data  = W2;
        tick();
        for (int i = 0; i < 2 * (LAST + 1); i++) begin
            in_valid = (i == 0);
            in_data  = W3;
            if (i <= LAST) check_byte("b2b a", W2, i);
            else           check_byte("b2b b", W3, i - LAST - 1);
            tick();
        end
        check("b2b idle", 72'(out_valid), 72'd0);
        check("b2b in_ready", 72'(in_ready), 72'd1);

        // stalled output: third word dropped
        out_ready = 1'b0;
        send(W1);
        send(W2);
        send(W3);
        check("full drop_cnt", 72'(drop_cnt), 72'd1);
        check("full in_ready", 72'(in_ready), 72'd0);
        check_byte("full hold", W1, 0);
        tick();
        check_byte("full hold2", W1, 0);
        out_ready = 1'b1;
        // free on last byte while full: the incoming word still drops
        for (int i = 0; i < 2 * (LAST + 1); i++) begin
            in_valid = (i == LAST);
            in_data  = W4;
            if (i <= LAST) check_byte("rel a", W1, i);
            else           check_byte("rel b", W2, i - LAST - 1);
            tick();
        end
        in_valid = 1'b0;
        check("rel drop_cnt", 72'(drop_cnt), 72'd2);
        check("rel idle", 72'(out_valid), 72'd0);

        // toggling out_ready
        out_ready = 1'b0;
        send(W5);
        k = 0;
        for (int c = 0; c < 40 && k <= LAST; c++) begin
            check_byte("tog", W5, k);
            out_ready = c[0];
            tick();
            if (out_ready) k++;
        end
        check("tog count", 72'(k), 72'(LAST + 1));
        out_ready = 1'b1;
        check("tog idle", 72'(out_valid), 72'd0);

        // asynchronous reset mid-word
        send(W1);
        for (int i = 0; i < 3; i++) begin
            check_byte("mid", W1, i);
            tick();
        end
        reset = 1'b1;
        #1;
        check("async out_valid", 72'(out_valid), 72'd0);
        check("async out_index", 72'(out_index), 72'd0);
        tick();
        reset = 1'b0;
        send(W2);
        for (int i = 0; i <= LAST; i++) begin
            check_byte("post", W2, i);
            tick();
        end
        check("post idle", 72'(out_valid), 72'd0);

        // drop counter saturation
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W3;
        for (int i = 0; i < 270; i++) tick();
        in_valid = 1'b0;
        check("sat drop_cnt", 72'(drop_cnt), 72'd255);
        check_byte("sat hold", W3, 0);
        do_reset();
        check("sat cleared", 72'(drop_cnt), 72'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
